forwarding_unit: RTL and testbench
==================================

// Module: forwarding_unit
// PURPOSE
//  - Data-hazard forwarding selector for the 4-stage-register pipelined CPU; sits in EX stage.
//  - Compares the ID/EX source registers against the EX/MEM and MEM/WB destination registers.
//  - Drives the two ALU-operand mux selects (forward_a, forward_b).
//  - Also keeps saturating performance counters of forwards taken (clocked side only).
// PARAMETERS
//  REG_AW      4   register-address width (16 architectural registers)
//  EXCLUDE_R0  0   1: a destination of register 0 never forwards; 0: r0 is an ordinary register
//  CNT_W       16  width of each forward-event counter
// PORTS
//  clk              in   1       system clock, rising edge
//  rst_n            in   1       asynchronous, active-low reset
//  r1_idex          in   REG_AW  source reg 1 of instruction in ID/EX
//  r2_idex          in   REG_AW  source reg 2 of instruction in ID/EX
//  rd_exmem         in   REG_AW  destination reg of instruction in EX/MEM
//  rd_memwb         in   REG_AW  destination reg of instruction in MEM/WB
//  reg_write_exmem  in   1       EX/MEM instruction writes the register file
//  reg_write_memwb  in   1       MEM/WB instruction writes the register file
//  cnt_clr          in   1       synchronous clear of both counters
//  forward_a        out  2       operand-A mux select
//  forward_b        out  2       operand-B mux select
//  fwd_ex_cnt       out  CNT_W   count of operands forwarded from EX/MEM
//  fwd_mem_cnt      out  CNT_W   count of operands forwarded from MEM/WB
// BEHAVIOUR
//  - Select encoding: 2'b00 = register-file value from ID/EX; 2'b10 = EX/MEM ALU result;
//    2'b01 = MEM/WB writeback value; 2'b11 never driven.
//  - forward_a and forward_b are purely combinational, zero latency.
//  - forward_a/forward_b do not depend on clk or rst_n; they are valid during reset.
//  - ex_hit(s)  = reg_write_exmem && rd_exmem == s && !(EXCLUDE_R0 && rd_exmem == 0).
//  - mem_hit(s) = reg_write_memwb && rd_memwb == s && !(EXCLUDE_R0 && rd_memwb == 0).
//  - forward_x = ex_hit(rx) ? 2'b10 : mem_hit(rx) ? 2'b01 : 2'b00.
//  - EX/MEM takes priority: it holds the most recent value.
//  - A and B are evaluated independently; both may select the same stage.
//  - Write-enable low masks a match completely, even when the register numbers are equal.
//  - Counters (posedge clk, async reset to 0):
//    - rst_n = 0: both counters = 0 immediately.
//    - cnt_clr = 1: both counters <= 0; clear overrides increments in the same cycle.
//    - Otherwise, each cycle fwd_ex_cnt += (forward_a==10) + (forward_b==10).
//    - Likewise fwd_mem_cnt += (forward_a==01) + (forward_b==01).
//    - Increment per cycle is 0..2.
//    - Saturate at all-ones; no wrap-around, including when an increment of 2 would overflow.
//  - Reset deasserted mid-operation: counting resumes from 0 on the next rising edge.
// STRUCTURE
//  - Shared package pipe_pkg: REG_AW; fwd_sel_t enum
//    (FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_EX=2'b10).
//  - One natural sub-module: fwd_sel_logic, instantiated twice (operand A and operand B).
//    It maps (src, rd_exmem, rd_memwb, write enables) to fwd_sel_t.
//  - Counters live in the top level.
// TESTING
//  1. r1=1,r2=1, rd_exmem=1 wr=1, rd_memwb=7 wr=1 -> forward_a=10, forward_b=10.
//  2. r1=3,r2=8, rd_exmem=11 wr=1, rd_memwb=14 wr=1 -> forward_a=00, forward_b=00.
//  3. r1=6,r2=9, rd_exmem=6 wr=0, rd_memwb=6 wr=1 -> forward_a=01, forward_b=00.
//  4. r1=1,r2=2, rd_exmem=1 wr=1, rd_memwb=0 wr=1 -> forward_a=10, forward_b=00.
//     Repeat with r2=0: forward_b=01 if EXCLUDE_R0=0, 00 if EXCLUDE_R0=1.
//  5. Hold case 1 for 3 clocks -> fwd_ex_cnt=6, fwd_mem_cnt=0.
//     Assert rst_n=0 between clock edges -> fwd_ex_cnt=0 at once.
//     Then cnt_clr together with hits -> counters stay 0.
//  6. CNT_W=4: preload fwd_ex_cnt to 14, apply case 1 (increment 2) -> 15 and holds at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-address width and the ALU operand
// forwarding select encoding used by the EX-stage muxes.
package pipe_pkg;

    localparam int REG_AW = 4;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_EX   = 2'b10
    } fwd_sel_t;

endpackage : pipe_pkg

// File: rtl/fwd_sel_logic.sv
// Forwarding select for one ALU operand: picks the youngest in-flight
// producer of the source register, or the register file if there is none.
module fwd_sel_logic #(
    parameter int REG_AW     = pipe_pkg::REG_AW,
    parameter bit EXCLUDE_R0 = 1'b0
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] rdExMem,
    input  logic [REG_AW-1:0] rdMemWb,
    input  logic              regWriteExMem,
    input  logic              regWriteMemWb,
    output pipe_pkg::fwd_sel_t sel
);
    import pipe_pkg::*;

    logic exHit;
    logic memHit;

    // A hardwired-zero r0 must never be forwarded when EXCLUDE_R0 is set.
    assign exHit  = regWriteExMem && (rdExMem == src) && !(EXCLUDE_R0 && (rdExMem == '0));
    assign memHit = regWriteMemWb && (rdMemWb == src) && !(EXCLUDE_R0 && (rdMemWb == '0));

    // EX/MEM holds the more recent value, so it wins over MEM/WB.
    always_comb begin
        sel = FWD_NONE;
        if (exHit) begin
            sel = FWD_EX;
        end else if (memHit) begin
            sel = FWD_MEM;
        end
    end

endmodule : fwd_sel_logic

// File: rtl/forwarding_unit.sv
// EX-stage data-hazard forwarding unit: combinational operand selects plus
// saturating counters of forwards taken from each pipeline stage.
module forwarding_unit #(
    parameter int REG_AW     = pipe_pkg::REG_AW,
    parameter bit EXCLUDE_R0 = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] r1_idex,
    input  logic [REG_AW-1:0] r2_idex,
    input  logic [REG_AW-1:0] rd_exmem,
    input  logic [REG_AW-1:0] rd_memwb,
    input  logic              reg_write_exmem,
    input  logic              reg_write_memwb,
    input  logic              cnt_clr,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic [CNT_W-1:0]  fwd_ex_cnt,
    output logic [CNT_W-1:0]  fwd_mem_cnt
);
    import pipe_pkg::*;

    logic [REG_AW-1:0] srcReg [2];
    fwd_sel_t          sel    [2];
    logic [CNT_W-1:0]  cntOut [2];

    assign srcReg[0] = r1_idex;
    assign srcReg[1] = r2_idex;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            fwd_sel_logic #(
                .REG_AW     (REG_AW),
                .EXCLUDE_R0 (EXCLUDE_R0)
            ) u_sel (
                .src           (srcReg[gi]),
                .rdExMem       (rd_exmem),
                .rdMemWb       (rd_memwb),
                .regWriteExMem (reg_write_exmem),
                .regWriteMemWb (reg_write_memwb),
                .sel           (sel[gi])
            );
        end

        // Counter 0 tracks EX/MEM forwards, counter 1 tracks MEM/WB forwards.
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            localparam fwd_sel_t KIND = (gi == 0) ? FWD_EX : FWD_MEM;

            logic [1:0]       inc;
            logic [CNT_W:0]   sum;
            logic [CNT_W-1:0] cntReg;
            logic [CNT_W-1:0] cntNext;

            // One spare bit on the sum catches overflow from a +2 step.
            always_comb begin
                inc     = {1'b0, sel[0] == KIND} + {1'b0, sel[1] == KIND};
                sum     = {1'b0, cntReg} + {{(CNT_W-1){1'b0}}, inc};
                cntNext = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
                if (cnt_clr) begin
                    cntNext = '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cntReg <= '0;
                end else begin
                    cntReg <= cntNext;
                end
            end

            assign cntOut[gi] = cntReg;
        end
    endgenerate

    assign forward_a   = sel[0];
    assign forward_b   = sel[1];
    assign fwd_ex_cnt  = cntOut[0];
    assign fwd_mem_cnt = cntOut[1];

endmodule : forwarding_unit

// File: tb/tb_forwarding_unit.sv
// Self-checking bench for forwarding_unit: two instances (r0 ordinary / 16-bit
// counters, and r0 excluded / 4-bit counters) against a behavioural model.
module tb_forwarding_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] r1, r2, rde, rdm;
    logic       we, wm, clr;

    logic [1:0]  fa0, fb0, fa1, fb1;
    logic [15:0] exCnt0, memCnt0;
    logic [3:0]  exCnt1, memCnt1;

    int testCnt = 0;
    int failCnt = 0;

    // model state
    int mEx0, mMem0, mEx1, mMem1;

    always #5 clk = ~clk;

    forwarding_unit #(.REG_AW(4), .EXCLUDE_R0(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .r1_idex(r1), .r2_idex(r2),
        .rd_exmem(rde), .rd_memwb(rdm), .reg_write_exmem(we), .reg_write_memwb(wm),
        .cnt_clr(clr), .forward_a(fa0), .forward_b(fb0),
        .fwd_ex_cnt(exCnt0), .fwd_mem_cnt(memCnt0)
    );

    forwarding_unit #(.REG_AW(4), .EXCLUDE_R0(1'b1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .r1_idex(r1), .r2_idex(r2),
        .rd_exmem(rde), .rd_memwb(rdm), .reg_write_exmem(we), .reg_write_memwb(wm),
        .cnt_clr(clr), .forward_a(fa1), .forward_b(fb1),
        .fwd_ex_cnt(exCnt1), .fwd_mem_cnt(memCnt1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        testCnt++;
        if (obs != exp) begin
            failCnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected select: 2 = EX/MEM, 1 = MEM/WB, 0 = register file.
    function automatic int refSel(int s, bit excl);
        bit exOk  = we && (int'(rde) == s) && !(excl && rde == 0);
        bit memOk = wm && (int'(rdm) == s) && !(excl && rdm == 0);
        if (exOk)  return 2;
        if (memOk) return 1;
        return 0;
    endfunction

    function automatic int satAdd(int cnt, int inc, int w);
        int maxVal = (1 << w) - 1;
        return (cnt + inc > maxVal) ? maxVal : cnt + inc;
    endfunction

    task automatic checkSel(input string tag);
        chk({tag, ".fa0"}, int'(fa0), refSel(int'(r1), 1'b0));
        chk({tag, ".fb0"}, int'(fb0), refSel(int'(r2), 1'b0));
        chk({tag, ".fa1"}, int'(fa1), refSel(int'(r1), 1'b1));
        chk({tag, ".fb1"}, int'(fb1), refSel(int'(r2), 1'b1));
    endtask

    task automatic checkCnt(input string tag);
        chk({tag, ".ex0"},  int'(exCnt0),  mEx0);
        chk({tag, ".mem0"}, int'(memCnt0), mMem0);
        chk({tag, ".ex1"},  int'(exCnt1),  mEx1);
        chk({tag, ".mem1"}, int'(memCnt1), mMem1);
    endtask

    // Apply one set of inputs, check the selects, clock once, check counters.
    task automatic step(input string tag, input int a, input int b, input int e,
                        input int m, input bit wE, input bit wM, input bit c);
        int a0, b0, a1, b1;
        r1 = 4'(a); r2 = 4'(b); rde = 4'(e); rdm = 4'(m);
        we = wE; wm = wM; clr = c;
        #1;
        checkSel(tag);
        a0 = refSel(a, 1'b0); b0 = refSel(b, 1'b0);
        a1 = refSel(a, 1'b1); b1 = refSel(b, 1'b1);
        @(posedge clk);
        if (clr) begin
            mEx0 = 0; mMem0 = 0; mEx1 = 0; mMem1 = 0;
        end else begin
            mEx0  = satAdd(mEx0,  int'(a0 == 2) + int'(b0 == 2), 16);
            mMem0 = satAdd(mMem0, int'(a0 == 1) + int'(b0 == 1), 16);
            mEx1  = satAdd(mEx1,  int'(a1 == 2) + int'(b1 == 2), 4);
            mMem1 = satAdd(mMem1, int'(a1 == 1) + int'(b1 == 1), 4);
        end
        #1;
        checkCnt(tag);
        $display("[TB] %s r1=%0d r2=%0d rde=%0d/%0b rdm=%0d/%0b clr=%0b fa=%0d fb=%0d ex=%0d mem=%0d",
                 tag, a, b, e, wE, m, wM, c, fa0, fb0, exCnt0, memCnt0);
    endtask

    initial begin
        rst_n = 1'b0;
        mEx0 = 0; mMem0 = 0; mEx1 = 0; mMem1 = 0;
        // selects must already be valid while reset is held
        r1 = 4'd6; r2 = 4'd9; rde = 4'd6; rdm = 4'd9; we = 1'b1; wm = 1'b1; clr = 1'b0;
        #2;
        checkSel("rst_sel");
        checkCnt("rst_cnt");
        #10;
        rst_n = 1'b1;

        // directed cases
        step("c1", 1, 1, 1, 7, 1, 1, 0);
        step("c2", 3, 8, 11, 14, 1, 1, 0);
        step("c3", 6, 9, 6, 6, 0, 1, 0);
        step("c4", 1, 2, 1, 0, 1, 1, 0);
        step("c4r0", 1, 0, 1, 0, 1, 1, 0);
        step("r0ex", 0, 0, 0, 5, 1, 1, 0);

        // hold case 1 for three clocks from a cleared state
        step("clr", 1, 1, 1, 7, 1, 1, 1);
        for (int i = 0; i < 3; i++) step("hold", 1, 1, 1, 7, 1, 1, 0);
        chk("hold.ex6", int'(exCnt0), 6);
        chk("hold.mem0", int'(memCnt0), 0);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        mEx0 = 0; mMem0 = 0; mEx1 = 0; mMem1 = 0;
        checkCnt("async_rst");
        #2;
        rst_n = 1'b1;
        step("clr_hit", 1, 1, 1, 1, 1, 1, 1);
        chk("clr_hit.ex", int'(exCnt0), 0);

        // 4-bit counter: reach 14, then saturate on a +2 step
        for (int i = 0; i < 7; i++) step("pre", 1, 1, 1, 7, 1, 1, 0);
        chk("pre.ex14", int'(exCnt1), 14);
        step("sat", 1, 1, 1, 7, 1, 1, 0);
        chk("sat.ex15", int'(exCnt1), 15);
        step("sat_hold", 1, 1, 1, 7, 1, 1, 0);
        chk("sat_hold.ex15", int'(exCnt1), 15);

        // randomized: small register range keeps hazards frequent
        for (int i = 0; i < 300; i++) begin
            step("rnd",
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule : tb_forwarding_unit
